noc_stream_receiver: RTL and testbench
======================================

NOC_STREAM_RECEIVER -- requirements
Module: noc_stream_receiver

Interface
REQ-001 SHALL have parameter noc_dw, default 512, meaning flit data width in bits.
REQ-002 SHALL have parameter byte_dw, default 8, meaning byte width; also the width of tid and tdest.
REQ-003 SHALL have parameter user_dw, default 32, meaning tuser width.
REQ-004 SHALL have parameter my_id, default 0, meaning the tdest value this endpoint accepts.
REQ-005 SHALL have parameter fifo_depth, default 4, meaning flit buffer entries; must be a power of 2 and at least 2.
REQ-006 SHALL have port clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-008 SHALL have port slave_tvalid, input, 1 bit: flit valid from the router adapter master side.
REQ-009 SHALL have port slave_tready, output, 1 bit: flit accept.
REQ-010 SHALL have ports slave_tdata/tstrb/tkeep/tid/tdest/tuser/tlast, inputs, with widths noc_dw, noc_dw/byte_dw, noc_dw/byte_dw, byte_dw, byte_dw, user_dw and 1 respectively: AXI-Stream flit fields.
REQ-011 SHALL have ports out_tvalid (output, 1), out_tready (input, 1), out_tdata (output, noc_dw), out_tkeep (output, noc_dw/byte_dw), out_tid (output, byte_dw), out_tuser (output, user_dw) and out_tlast (output, 1): downstream user stream.
REQ-012 SHALL have ports pkt_count and drop_count, outputs, 16 bits each: saturating counters of delivered and dropped packets.
REQ-013 SHALL have port dest_err, output, 1 bit: sticky flag, set when any packet is dropped.

Function
REQ-014 SHALL transfer a slave flit only when slave_tvalid and slave_tready are both 1 at a clk edge, and a downstream flit only when out_tvalid and out_tready are both 1.
REQ-015 SHALL implement an FSM with three states:
- IDLE: awaiting the first flit of a packet.
- ACCEPT: packet is being buffered.
- DROP: packet is being discarded.
REQ-016 In IDLE, on a first-flit handshake, SHALL go to ACCEPT and write the flit if tdest==my_id, otherwise go to DROP and discard the flit; if that flit has tlast=1, SHALL instead stay in IDLE with the same write/discard action.
REQ-017 In ACCEPT, SHALL write every handshaken flit and return to IDLE after the flit with tlast=1.
REQ-018 In DROP, SHALL hold slave_tready=1 regardless of FIFO level, discard flits, and return to IDLE after the flit with tlast=1.
REQ-019 In IDLE and ACCEPT, slave_tready SHALL equal NOT fifo_full; it is combinational from state and occupancy, with no dependence on slave_tvalid.
REQ-020 The FIFO SHALL be first-word-fall-through:
- out_tvalid = NOT empty.
- out_* fields show the head entry, stored as tdata, tkeep, tid, tuser and tlast.
- tstrb and tdest are not stored.
REQ-021 A simultaneous push and pop SHALL leave occupancy unchanged, and SHALL be legal both when empty (count 0 to 1 to 0 is not required; the pop refers to the old head only) and when full (slave_tready is 0, so no push occurs).
REQ-022 Read and write pointers SHALL wrap modulo fifo_depth, with one extra bit used to distinguish full from empty.
REQ-023 pkt_count SHALL increment on each downstream handshake with out_tlast=1 and saturate at 16'hFFFF.
REQ-024 drop_count SHALL increment when a tlast=1 flit is discarded, and saturate at 16'hFFFF.
REQ-025 dest_err SHALL set in the same cycle drop_count increments and clear only on reset.
REQ-026 Latency SHALL be one cycle, from slave handshake to out_tvalid=1 with an empty FIFO.

Reset
REQ-027 While reset=1, SHALL force slave_tready=0 and out_tvalid=0.
REQ-028 On reset, SHALL set state=IDLE, pointers=0, pkt_count=0, drop_count=0 and dest_err=0.
REQ-029 Reset asserted mid-packet SHALL discard FIFO contents and any partial packet; the first flit after reset is treated as a packet head.

Structure
REQ-030 A shared package noc_stream_pkg SHALL hold:
- the FSM state enum (IDLE, ACCEPT, DROP);
- the 16-bit counter width constant;
- the flit record layout (data, keep, id, user, last).
REQ-031 The buffer SHALL be one sub-module, noc_flit_fifo, parameterised by width and depth, with push/pop/full/empty ports.

Verification
REQ-032 Bench: 3-flit packet with tdest=0, tdata=1,2,3, and out_tready=1 -> out_tdata 1,2,3 starting one cycle after each accept, out_tlast only on 3, pkt_count=1.
REQ-033 Bench: 2-flit packet with tdest=5 (my_id=0) -> no out_tvalid, slave_tready=1 throughout, drop_count=1, dest_err=1.
REQ-034 Bench: out_tready=0 and 6 flits offered with depth 4 -> exactly 4 accepted, slave_tready=0 from then on; release out_tready -> all 6 delivered in order, each pop reopening one slot.
REQ-035 Bench: single-flit packet (tlast=1 on the head) to my_id, back-to-back with a dropped single-flit packet -> pkt_count=1, drop_count=1, state IDLE after each.
REQ-036 Bench: reset asserted after flit 2 of 4 -> FIFO empty and counters 0 the next cycle; a new 1-flit packet is delivered normally.
REQ-037 Bench: preload pkt_count to 16'hFFFE via 2 delivered packets plus a force -> count stays at 16'hFFFF, with no wrap.

Source files
------------

// File: rtl/noc_stream_pkg.sv
// Shared types for the NoC stream receiver endpoint.
// Holds the receive FSM states, counter width and flit record layout.
package noc_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    DROP
  } rx_state_t;

  localparam int CNT_W = 16;

  localparam int DEF_NOC_DW  = 512;
  localparam int DEF_BYTE_DW = 8;
  localparam int DEF_USER_DW = 32;

  // Buffered flit layout, MSB first; tstrb and tdest are not kept.
  typedef struct packed {
    logic [DEF_NOC_DW-1:0]             data;
    logic [DEF_NOC_DW/DEF_BYTE_DW-1:0] keep;
    logic [DEF_BYTE_DW-1:0]            id;
    logic [DEF_USER_DW-1:0]            user;
    logic                              last;
  } flit_t;

  function automatic int flit_w(
    input int noc_dw,
    input int byte_dw,
    input int user_dw
  );
    return noc_dw + noc_dw / byte_dw + byte_dw + user_dw + 1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// First-word-fall-through flit buffer.
// Pointers carry one extra wrap bit to tell full from empty.
module noc_flit_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] wdata,
  input  logic             pop,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int aw = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [aw:0]      wr_ptr;
  logic [aw:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[aw] != rd_ptr[aw]) &&
                 (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign rdata = mem[rd_ptr[aw-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + (aw+1)'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + (aw+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr[aw-1:0]] <= wdata;
  end

endmodule

// File: rtl/noc_stream_receiver.sv
// NoC endpoint: keeps packets addressed to my_id, drops the rest,
// and hands kept flits downstream through a small FWFT buffer.
module noc_stream_receiver
  import noc_stream_pkg::*;
#(
  parameter int noc_dw     = 512,
  parameter int byte_dw    = 8,
  parameter int user_dw    = 32,
  parameter int my_id      = 0,
  parameter int fifo_depth = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    slave_tvalid,
  output logic                    slave_tready,
  input  logic [noc_dw-1:0]       slave_tdata,
  input  logic [noc_dw/byte_dw-1:0] slave_tstrb,
  input  logic [noc_dw/byte_dw-1:0] slave_tkeep,
  input  logic [byte_dw-1:0]      slave_tid,
  input  logic [byte_dw-1:0]      slave_tdest,
  input  logic [user_dw-1:0]      slave_tuser,
  input  logic                    slave_tlast,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic [noc_dw-1:0]       out_tdata,
  output logic [noc_dw/byte_dw-1:0] out_tkeep,
  output logic [byte_dw-1:0]      out_tid,
  output logic [user_dw-1:0]      out_tuser,
  output logic                    out_tlast,
  output logic [CNT_W-1:0]        pkt_count,
  output logic [CNT_W-1:0]        drop_count,
  output logic                    dest_err
);

  localparam int fw = flit_w(noc_dw, byte_dw, user_dw);

  rx_state_t        state;
  rx_state_t        state_nx;
  logic             full;
  logic             empty;
  logic             hs;
  logic             for_me;
  logic             push;
  logic             drop_last;
  logic             pop;
  logic [fw-1:0]    wdata;
  logic [fw-1:0]    rdata;
  logic [CNT_W-1:0] pkt_cnt_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             err_q;
  logic             unused_tstrb;

  assign unused_tstrb = ^slave_tstrb;

  assign for_me = (slave_tdest == byte_dw'(my_id));
  assign hs     = slave_tvalid & slave_tready;
  assign pop    = out_tvalid & out_tready;

  always_comb begin
    state_nx     = state;
    slave_tready = 1'b0;
    push         = 1'b0;
    drop_last    = 1'b0;
    unique case (state)
      IDLE: begin
        slave_tready = ~full;
        if (hs) begin
          push      = for_me;
          drop_last = ~for_me & slave_tlast;
          if (!slave_tlast)
            state_nx = for_me ? ACCEPT : DROP;
        end
      end
      ACCEPT: begin
        slave_tready = ~full;
        push         = hs;
        if (hs && slave_tlast)
          state_nx = IDLE;
      end
      DROP: begin
        slave_tready = 1'b1;
        drop_last    = hs & slave_tlast;
        if (hs && slave_tlast)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Nothing is taken while reset is held.
    if (reset) begin
      slave_tready = 1'b0;
      push         = 1'b0;
      drop_last    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  assign wdata = {slave_tdata, slave_tkeep, slave_tid,
                  slave_tuser, slave_tlast};

  noc_flit_fifo #(
    .width (fw),
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign out_tvalid = ~reset & ~empty;
  assign {out_tdata, out_tkeep, out_tid,
          out_tuser, out_tlast} = rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (pop && out_tlast)
        pkt_cnt_q <= sat_inc(pkt_cnt_q);
      if (drop_last) begin
        drop_cnt_q <= sat_inc(drop_cnt_q);
        err_q      <= 1'b1;
      end
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign drop_count = drop_cnt_q;
  assign dest_err   = err_q;

endmodule

// File: tb/tb_noc_stream_receiver.sv
// Directed bench for noc_stream_receiver.
// Inputs change and outputs are sampled on the falling edge.
module tb_noc_stream_receiver;
  import noc_stream_pkg::*;

  localparam int NDW = 32;
  localparam int BDW = 8;
  localparam int UDW = 32;
  localparam int KW  = NDW / BDW;

  logic           clk = 1'b0;
  logic           reset;
  logic           slave_tvalid;
  logic           slave_tready;
  logic [NDW-1:0] slave_tdata;
  logic [KW-1:0]  slave_tstrb;
  logic [KW-1:0]  slave_tkeep;
  logic [BDW-1:0] slave_tid;
  logic [BDW-1:0] slave_tdest;
  logic [UDW-1:0] slave_tuser;
  logic           slave_tlast;
  logic           out_tvalid;
  logic           out_tready;
  logic [NDW-1:0] out_tdata;
  logic [KW-1:0]  out_tkeep;
  logic [BDW-1:0] out_tid;
  logic [UDW-1:0] out_tuser;
  logic           out_tlast;
  logic [15:0]    pkt_count;
  logic [15:0]    drop_count;
  logic           dest_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  noc_stream_receiver #(
    .noc_dw     (NDW),
    .byte_dw    (BDW),
    .user_dw    (UDW),
    .my_id      (0),
    .fifo_depth (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .slave_tvalid (slave_tvalid),
    .slave_tready (slave_tready),
    .slave_tdata  (slave_tdata),
    .slave_tstrb  (slave_tstrb),
    .slave_tkeep  (slave_tkeep),
    .slave_tid    (slave_tid),
    .slave_tdest  (slave_tdest),
    .slave_tuser  (slave_tuser),
    .slave_tlast  (slave_tlast),
    .out_tvalid   (out_tvalid),
    .out_tready   (out_tready),
    .out_tdata    (out_tdata),
    .out_tkeep    (out_tkeep),
    .out_tid      (out_tid),
    .out_tuser    (out_tuser),
    .out_tlast    (out_tlast),
    .pkt_count    (pkt_count),
    .drop_count   (drop_count),
    .dest_err     (dest_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d,
                       input logic [7:0] dest, input logic last);
    slave_tvalid = v;
    slave_tdata  = d;
    slave_tdest  = dest;
    slave_tlast  = last;
    slave_tkeep  = '1;
    slave_tstrb  = '1;
    slave_tid    = 8'h3c;
    slave_tuser  = d ^ 32'hA5A5_0000;
  endtask

  initial begin
    reset      = 1'b1;
    out_tready = 1'b0;
    drive(1'b0, 0, 0, 1'b0);

    // reset behaviour
    @(negedge clk);
    chk("rst_tready", 32'(slave_tready), 0);
    chk("rst_ovalid", 32'(out_tvalid), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("init_pkt", 32'(pkt_count), 0);
    chk("init_drop", 32'(drop_count), 0);
    chk("init_err", 32'(dest_err), 0);
    chk("init_ovalid", 32'(out_tvalid), 0);
    chk("init_tready", 32'(slave_tready), 1);

    // 3-flit packet to my_id
    out_tready = 1'b1;
    drive(1'b1, 1, 0, 1'b0);
    @(negedge clk);
    chk("p1_v1", 32'(out_tvalid), 1);
    chk("p1_d1", out_tdata, 1);
    chk("p1_l1", 32'(out_tlast), 0);
    chk("p1_user", out_tuser, 32'hA5A5_0001);
    chk("p1_keep", 32'(out_tkeep), 32'hf);
    chk("p1_id", 32'(out_tid), 32'h3c);
    drive(1'b1, 2, 0, 1'b0);
    @(negedge clk);
    chk("p1_d2", out_tdata, 2);
    chk("p1_l2", 32'(out_tlast), 0);
    drive(1'b1, 3, 0, 1'b1);
    @(negedge clk);
    chk("p1_d3", out_tdata, 3);
    chk("p1_l3", 32'(out_tlast), 1);
    drive(1'b0, 0, 0, 1'b0);
    @(negedge clk);
    chk("p1_done_v", 32'(out_tvalid), 0);
    chk("p1_pkt", 32'(pkt_count), 1);

    // 2-flit packet to another endpoint
    drive(1'b1, 8, 5, 1'b0);
    chk("drop_rdy1", 32'(slave_tready), 1);
    @(negedge clk);
    chk("drop_state", 32'(dut.state), 32'(DROP));
    chk("drop_rdy2", 32'(slave_tready), 1);
    chk("drop_v1", 32'(out_tvalid), 0);
    drive(1'b1, 9, 5, 1'b1);
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b0);
    chk("drop_v2", 32'(out_tvalid), 0);
    chk("drop_cnt", 32'(drop_count), 1);
    chk("drop_err", 32'(dest_err), 1);

    // backpressure: 6 flits into depth-4 buffer
    out_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(10 + i), 0, 1'b0);
      chk($sformatf("bp_rdy%0d", i), 32'(slave_tready), 1);
      @(negedge clk);
    end
    drive(1'b1, 14, 0, 1'b0);
    chk("bp_full1", 32'(slave_tready), 0);
    chk("bp_head", out_tdata, 10);
    @(negedge clk);
    chk("bp_full2", 32'(slave_tready), 0);
    out_tready = 1'b1;
    @(negedge clk);
    chk("bp_reopen", 32'(slave_tready), 1);
    chk("bp_d11", out_tdata, 11);
    @(negedge clk);
    chk("bp_d12", out_tdata, 12);
    drive(1'b1, 15, 0, 1'b1);
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b0);
    chk("bp_d13", out_tdata, 13);
    @(negedge clk);
    chk("bp_d14", out_tdata, 14);
    chk("bp_l14", 32'(out_tlast), 0);
    @(negedge clk);
    chk("bp_d15", out_tdata, 15);
    chk("bp_l15", 32'(out_tlast), 1);
    @(negedge clk);
    chk("bp_empty", 32'(out_tvalid), 0);
    chk("bp_pkt", 32'(pkt_count), 2);

    // single-flit kept packet then single-flit dropped packet
    drive(1'b1, 20, 0, 1'b1);
    @(negedge clk);
    chk("sf_state1", 32'(dut.state), 32'(IDLE));
    chk("sf_d20", out_tdata, 20);
    chk("sf_l20", 32'(out_tlast), 1);
    drive(1'b1, 21, 5, 1'b1);
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b0);
    chk("sf_state2", 32'(dut.state), 32'(IDLE));
    chk("sf_pkt", 32'(pkt_count), 3);
    chk("sf_drop", 32'(drop_count), 2);
    chk("sf_v", 32'(out_tvalid), 0);

    // reset mid-packet
    out_tready = 1'b0;
    drive(1'b1, 30, 0, 1'b0);
    @(negedge clk);
    drive(1'b1, 31, 0, 1'b0);
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b0);
    chk("mr_pre_v", 32'(out_tvalid), 1);
    reset = 1'b1;
    #1;
    chk("mr_rdy", 32'(slave_tready), 0);
    chk("mr_ov", 32'(out_tvalid), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mr_empty", 32'(out_tvalid), 0);
    chk("mr_pkt", 32'(pkt_count), 0);
    chk("mr_drop", 32'(drop_count), 0);
    chk("mr_err", 32'(dest_err), 0);
    chk("mr_state", 32'(dut.state), 32'(IDLE));
    out_tready = 1'b1;
    drive(1'b1, 40, 0, 1'b1);
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b0);
    chk("mr_new_v", 32'(out_tvalid), 1);
    chk("mr_new_d", out_tdata, 40);
    chk("mr_new_l", 32'(out_tlast), 1);
    @(negedge clk);
    chk("mr_new_pkt", 32'(pkt_count), 1);

    // saturation of pkt_count
    drive(1'b1, 41, 0, 1'b1);
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b0);
    @(negedge clk);
    chk("sat_two", 32'(pkt_count), 2);
    force dut.pkt_cnt_q = 16'hFFFE;
    #1;
    release dut.pkt_cnt_q;
    #1;
    chk("sat_pre", 32'(pkt_count), 32'hFFFE);
    drive(1'b1, 50, 0, 1'b1);
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b0);
    @(negedge clk);
    chk("sat_ffff", 32'(pkt_count), 32'hFFFF);
    drive(1'b1, 51, 0, 1'b1);
    @(negedge clk);
    drive(1'b0, 0, 0, 1'b0);
    @(negedge clk);
    chk("sat_hold", 32'(pkt_count), 32'hFFFF);
    chk("sat_drop", 32'(drop_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
